// File: rtl/sdram_init_cfg_pkg.sv
// SDRAM init sequencer shared types: command codes, FSM states, mode word helpers.
// Latency: n/a (declarations and constant functions only).
// Backpressure: n/a.
package sdram_init_pkg;

  localparam int CMD_W = 4;
  typedef logic [CMD_W-1:0] cmd_t;

  // {CS#, RAS#, CAS#, WE#}
  localparam cmd_t CMD_NOP = 4'b0111;
  localparam cmd_t CMD_PRE = 4'b0010;
  localparam cmd_t CMD_AR  = 4'b0001;
  localparam cmd_t CMD_MRS = 4'b0000;

  // Command states last one cycle; the T* states cover the NOP gap after them.
  typedef enum logic [3:0] {
    ST_PWR,
    ST_PRE,
    ST_TRP,
    ST_AR,
    ST_TRFC,
    ST_MRS,
    ST_TMRD,
    ST_EMRS,
    ST_TEMRD,
    ST_DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Burst length field A2:0; 0 means full page.
  function automatic logic [2:0] bl_code(input int bl);
    logic [2:0] c;
    case (bl)
      1:       c = 3'b000;
      2:       c = 3'b001;
      4:       c = 3'b010;
      8:       c = 3'b011;
      default: c = 3'b111;
    endcase
    return c;
  endfunction

  // Mode register word A10:0; callers zero-extend to the full address width.
  function automatic logic [10:0] mrs_word(input int cas, input int bl,
                                           input int bt, input int wb);
    logic [10:0] w;
    w      = '0;
    w[9]   = 1'(wb);
    w[6:4] = 3'(cas);
    w[3]   = 1'(bt);
    w[2:0] = bl_code(bl);
    return w;
  endfunction

endpackage

// File: rtl/sdram_init_cfg_if.sv
// Command bus from the init sequencer to the controller's command arbiter.
// Latency: n/a (wires only).
// Backpressure: none; the arbiter passes these through until init_end is high.
interface sdram_init_cfg_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  import sdram_init_pkg::*;

  logic              init_req;
  logic              init_busy;
  logic              init_end;
  cmd_t              init_cmd;
  logic [BA_W-1:0]   init_bank;
  logic [ADDR_W-1:0] init_addr;

  modport master (
    input  init_req,
    output init_busy,
    output init_end,
    output init_cmd,
    output init_bank,
    output init_addr
  );

  modport slave (
    output init_req,
    input  init_busy,
    input  init_end,
    input  init_cmd,
    input  init_bank,
    input  init_addr
  );
endinterface

// File: rtl/sdram_init_cfg_dly.sv
// Loadable saturating down-counter timing every wait of the init sequence.
// Latency: done is high in the cycle the count sits at 1, i.e. value-1 cycles after load.
// Backpressure: none; a load always wins over counting.
module sdram_init_dly #(
  parameter int W = 15
) (
  input  logic         init_clk,
  input  logic         init_rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done,
  output logic         idle
);

  logic [W-1:0] cnt;

  // Count down to zero and hold there; a load restarts the interval.
  always_ff @(posedge init_clk) begin
    if (init_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));
  assign idle = (cnt == '0);

endmodule

// File: rtl/sdram_init_cfg.sv
// SDRAM power-up init sequencer: wait, PRE-ALL, N_AR x AR, MRS, optional EMRS; re-runnable.
// Latency: all outputs registered; commands spaced exactly by the issuing command's timing.
// Backpressure: none; init_req is a one-cycle pulse honoured only once the sequence is done.
module sdram_init_cfg
  import sdram_init_pkg::*;
#(
  parameter int              ADDR_W      = 13,
  parameter int              BA_W        = 2,
  parameter int              T_PWR       = 20000,
  parameter int              T_RP        = 2,
  parameter int              T_RFC       = 7,
  parameter int              T_MRD       = 2,
  parameter int              N_AR        = 2,
  parameter int              CAS_LAT     = 3,
  parameter int              BURST_LEN   = 0,
  parameter int              BURST_TYPE  = 0,
  parameter int              WRITE_BURST = 0,
  parameter int              EMRS_EN     = 0,
  parameter logic [ADDR_W-1:0] EMRS_VAL  = '0
) (
  input  logic               init_clk,
  input  logic               init_rst,
  sdram_init_cfg_if.master   bus
);

  // Parameter legality is settled at elaboration.
  if (ADDR_W < 11) begin : g_err_addr_w
    $error("sdram_init_cfg: ADDR_W must be >= 11");
  end
  if (BA_W < 1 || (EMRS_EN != 0 && BA_W < 2)) begin : g_err_ba_w
    $error("sdram_init_cfg: BA_W too small");
  end
  if (T_PWR < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1) begin : g_err_timing
    $error("sdram_init_cfg: all timings must be >= 1");
  end
  if (N_AR < 1 || N_AR > 15) begin : g_err_n_ar
    $error("sdram_init_cfg: N_AR must be 1..15");
  end
  if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_err_cas
    $error("sdram_init_cfg: CAS_LAT must be 2 or 3");
  end
  if (BURST_LEN != 0 && BURST_LEN != 1 && BURST_LEN != 2 &&
      BURST_LEN != 4 && BURST_LEN != 8) begin : g_err_bl
    $error("sdram_init_cfg: BURST_LEN must be 0, 1, 2, 4 or 8");
  end
  if (BURST_TYPE < 0 || BURST_TYPE > 1 || WRITE_BURST < 0 || WRITE_BURST > 1 ||
      EMRS_EN < 0 || EMRS_EN > 1) begin : g_err_flags
    $error("sdram_init_cfg: BURST_TYPE, WRITE_BURST and EMRS_EN must be 0 or 1");
  end

  localparam int T_MAX = max2(max2(T_PWR, T_RP), max2(T_RFC, T_MRD));
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0]  LD_PWR   = CNT_W'(T_PWR);
  localparam logic [CNT_W-1:0]  LD_RP    = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0]  LD_RFC   = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0]  LD_MRD   = CNT_W'(T_MRD);
  localparam logic [3:0]        AR_LAST  = 4'(N_AR);
  localparam logic [ADDR_W-1:0] MRS_ADDR =
    ADDR_W'(mrs_word(CAS_LAT, BURST_LEN, BURST_TYPE, WRITE_BURST));
  localparam logic [BA_W-1:0]   EMRS_BA  = BA_W'(2);

  state_t            state;
  logic [3:0]        ar_cnt;
  cmd_t              cmd_q;
  logic [BA_W-1:0]   bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              end_q;

  logic              dly_load;
  logic [CNT_W-1:0]  dly_val;
  logic              dly_done;
  logic              dly_idle;

  sdram_init_dly #(
    .W (CNT_W)
  ) u_dly (
    .init_clk (init_clk),
    .init_rst (init_rst),
    .load     (dly_load),
    .value    (dly_val),
    .done     (dly_done),
    .idle     (dly_idle)
  );

  // Arm the shared timer in the same edge a command is issued, with that command's timing.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    case (state)
      ST_PWR: begin
        if (dly_idle) begin
          dly_load = 1'b1;
          dly_val  = LD_PWR;
        end else if (dly_done) begin
          dly_load = 1'b1;
          dly_val  = LD_RP;
        end
      end
      ST_PRE, ST_TRP: begin
        if (dly_done) begin
          dly_load = 1'b1;
          dly_val  = LD_RFC;
        end
      end
      ST_AR, ST_TRFC: begin
        if (dly_done) begin
          dly_load = 1'b1;
          dly_val  = (ar_cnt == AR_LAST) ? LD_MRD : LD_RFC;
        end
      end
      ST_MRS, ST_TMRD: begin
        if (dly_done && EMRS_EN != 0) begin
          dly_load = 1'b1;
          dly_val  = LD_MRD;
        end
      end
      ST_DONE: begin
        if (bus.init_req) begin
          dly_load = 1'b1;
          dly_val  = LD_RP;
        end
      end
      default: begin
        dly_load = 1'b0;
      end
    endcase
  end

  // Sequence FSM; every command and status output is registered here.
  always_ff @(posedge init_clk) begin
    if (init_rst) begin
      state  <= ST_PWR;
      ar_cnt <= '0;
      cmd_q  <= CMD_NOP;
      bank_q <= '1;
      addr_q <= '1;
      busy_q <= 1'b1;
      end_q  <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      bank_q <= '1;
      addr_q <= '1;
      case (state)
        ST_PWR: begin
          if (dly_done) begin
            state  <= ST_PRE;
            cmd_q  <= CMD_PRE;
            ar_cnt <= '0;
          end
        end
        ST_PRE, ST_TRP: begin
          if (dly_done) begin
            state  <= ST_AR;
            cmd_q  <= CMD_AR;
            ar_cnt <= ar_cnt + 4'd1;
          end else begin
            state <= ST_TRP;
          end
        end
        ST_AR, ST_TRFC: begin
          if (dly_done) begin
            if (ar_cnt == AR_LAST) begin
              state  <= ST_MRS;
              cmd_q  <= CMD_MRS;
              bank_q <= '0;
              addr_q <= MRS_ADDR;
            end else begin
              state  <= ST_AR;
              cmd_q  <= CMD_AR;
              ar_cnt <= (ar_cnt == 4'hF) ? ar_cnt : ar_cnt + 4'd1;
            end
          end else begin
            state <= ST_TRFC;
          end
        end
        ST_MRS, ST_TMRD: begin
          if (dly_done) begin
            if (EMRS_EN != 0) begin
              state  <= ST_EMRS;
              cmd_q  <= CMD_MRS;
              bank_q <= EMRS_BA;
              addr_q <= EMRS_VAL;
            end else begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              end_q  <= 1'b1;
            end
          end else begin
            state <= ST_TMRD;
          end
        end
        ST_EMRS, ST_TEMRD: begin
          if (dly_done) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            end_q  <= 1'b1;
          end else begin
            state <= ST_TEMRD;
          end
        end
        ST_DONE: begin
          // Re-init skips the power-up wait and goes straight to PRE.
          if (bus.init_req) begin
            state  <= ST_PRE;
            cmd_q  <= CMD_PRE;
            ar_cnt <= '0;
            busy_q <= 1'b1;
            end_q  <= 1'b0;
          end
        end
        default: begin
          state <= ST_PWR;
        end
      endcase
    end
  end

  assign bus.init_cmd  = cmd_q;
  assign bus.init_bank = bank_q;
  assign bus.init_addr = addr_q;
  assign bus.init_busy = busy_q;
  assign bus.init_end  = end_q;

endmodule

// File: tb/tb_sdram_init_cfg.sv
// Bench for sdram_init_cfg: three configurations checked every cycle against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_init_cfg;

  localparam int TP   = 20;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TMRD = 2;
  localparam int NAR  = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        busy;
    logic        fin;
    logic        ar;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = -1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   base [3];
  int   t0, t1, t2;

  sdram_init_cfg_if #(.ADDR_W(13), .BA_W(2)) ifa ();
  sdram_init_cfg_if #(.ADDR_W(13), .BA_W(2)) ifb ();
  sdram_init_cfg_if #(.ADDR_W(13), .BA_W(2)) ifc ();

  sdram_init_cfg #(.T_PWR(TP)) u_a (
    .init_clk (clk), .init_rst (rst), .bus (ifa)
  );
  sdram_init_cfg #(.T_PWR(TP), .EMRS_EN(1), .EMRS_VAL(13'h020)) u_b (
    .init_clk (clk), .init_rst (rst), .bus (ifb)
  );
  sdram_init_cfg #(.T_PWR(TP), .CAS_LAT(2), .BURST_LEN(8), .BURST_TYPE(1),
                   .WRITE_BURST(1)) u_c (
    .init_clk (clk), .init_rst (rst), .bus (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] exp_mrs(input int cas, input int bl, input int bt, input int wb);
    int code;
    case (bl)
      1: code = 0;
      2: code = 1;
      4: code = 2;
      8: code = 3;
      default: code = 7;
    endcase
    return 13'(wb * 512 + cas * 16 + bt * 8 + code);
  endfunction

  function automatic int emrs_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic logic [12:0] mrs_of(input int i);
    return (i == 2) ? exp_mrs(2, 8, 1, 1) : exp_mrs(3, 0, 0, 0);
  endfunction

  function automatic int total_of(input int i);
    return TRP + NAR * TRFC + TMRD * (1 + emrs_of(i));
  endfunction

  // Outputs expected o cycles after the sequence's PRE (o < 0: still waiting).
  function automatic exp_t model(input int i, input int o);
    exp_t e;
    int   t_mrs;
    t_mrs  = TRP + NAR * TRFC;
    e.cmd  = NOP;
    e.bank = 2'b11;
    e.addr = 13'h1FFF;
    e.busy = 1'b1;
    e.fin  = 1'b0;
    e.ar   = 1'b0;
    if (o >= total_of(i)) begin
      e.busy = 1'b0;
      e.fin  = 1'b1;
    end else if (o == 0) begin
      e.cmd = PRE;
    end else if (o >= TRP && o < t_mrs && ((o - TRP) % TRFC) == 0) begin
      e.cmd = AR;
      e.ar  = 1'b1;
    end else if (o == t_mrs) begin
      e.cmd  = MRS;
      e.bank = 2'b00;
      e.addr = mrs_of(i);
    end else if (emrs_of(i) != 0 && o == t_mrs + TMRD) begin
      e.cmd  = MRS;
      e.bank = 2'b10;
      e.addr = 13'h020;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  // Model update: reset restarts the power-up wait; a request seen in DONE restarts at PRE.
  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      logic req;
      req = (i == 0) ? ifa.init_req : (i == 1) ? ifb.init_req : ifc.init_req;
      if (rst) begin
        base[i] = edge_n + 1 + TP;
      end else if (req && (edge_n - 1 - base[i]) >= total_of(i)) begin
        base[i] = edge_n;
      end
    end
  end

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    exp_t        e;
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic        bz, fn;
    string       nm;
    if (edge_n >= 0) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: begin c = ifa.init_cmd; b = ifa.init_bank; a = ifa.init_addr;
                   bz = ifa.init_busy; fn = ifa.init_end; nm = "A"; end
          1: begin c = ifb.init_cmd; b = ifb.init_bank; a = ifb.init_addr;
                   bz = ifb.init_busy; fn = ifb.init_end; nm = "B"; end
          default: begin c = ifc.init_cmd; b = ifc.init_bank; a = ifc.init_addr;
                   bz = ifc.init_busy; fn = ifc.init_end; nm = "C"; end
        endcase
        e = model(i, edge_n - base[i]);
        chk({nm, ".cmd"}, 32'(c), 32'(e.cmd));
        if (!e.ar) begin
          chk({nm, ".bank"}, 32'(b), 32'(e.bank));
          chk({nm, ".addr"}, 32'(a), 32'(e.addr));
        end
        chk({nm, ".busy"}, 32'(bz), 32'(e.busy));
        chk({nm, ".end"}, 32'(fn), 32'(e.fin));
      end
    end
  end

  task automatic goto(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  initial begin
    ifa.init_req = 1'b0;
    ifb.init_req = 1'b0;
    ifc.init_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.cmd", 32'(ifa.init_cmd), 32'h7);
    chk("reset.addr", 32'(ifa.init_addr), 32'h1FFF);
    chk("reset.busy", 32'(ifa.init_busy), 32'h1);
    chk("reset.end", 32'(ifa.init_end), 32'h0);
    rst = 1'b0;
    t0 = edge_n + 1;

    // Default sequence, EMRS and mode-word variants, with an ignored request at 25.
    goto(t0 + 19); chk("lit.A.nop19", 32'(ifa.init_cmd), 32'h7);
    goto(t0 + 20); chk("lit.A.pre20", 32'(ifa.init_cmd), 32'h2);
    goto(t0 + 22); chk("lit.A.ar22", 32'(ifa.init_cmd), 32'h1);
    goto(t0 + 25); ifa.init_req = 1'b1;
    goto(t0 + 26); ifa.init_req = 1'b0;
    goto(t0 + 29); chk("lit.A.ar29", 32'(ifa.init_cmd), 32'h1);
    goto(t0 + 36);
    chk("lit.A.mrs36", 32'(ifa.init_cmd), 32'h0);
    chk("lit.A.mrs_addr", 32'(ifa.init_addr), 32'h037);
    chk("lit.A.mrs_bank", 32'(ifa.init_bank), 32'h0);
    chk("lit.C.mrs_addr", 32'(ifc.init_addr), 32'h22B);
    goto(t0 + 37); chk("lit.A.end37", 32'(ifa.init_end), 32'h0);
    goto(t0 + 38);
    chk("lit.A.end38", 32'(ifa.init_end), 32'h1);
    chk("lit.A.busy38", 32'(ifa.init_busy), 32'h0);
    chk("lit.B.emrs38", 32'(ifb.init_cmd), 32'h0);
    chk("lit.B.emrs_bank", 32'(ifb.init_bank), 32'h2);
    chk("lit.B.emrs_addr", 32'(ifb.init_addr), 32'h020);
    goto(t0 + 39); chk("lit.B.end39", 32'(ifb.init_end), 32'h0);
    goto(t0 + 40); chk("lit.B.end40", 32'(ifb.init_end), 32'h1);

    // Re-init from DONE.
    goto(t0 + 50); ifa.init_req = 1'b1;
    goto(t0 + 51); ifa.init_req = 1'b0;
    chk("lit.A.repre51", 32'(ifa.init_cmd), 32'h2);
    chk("lit.A.reend51", 32'(ifa.init_end), 32'h0);
    chk("lit.A.rebusy51", 32'(ifa.init_busy), 32'h1);
    goto(t0 + 68); chk("lit.A.reend68", 32'(ifa.init_end), 32'h0);
    goto(t0 + 69); chk("lit.A.reend69", 32'(ifa.init_end), 32'h1);

    // Fresh power-up, then a one-cycle reset during TRFC.
    goto(t0 + 75); rst = 1'b1;
    goto(t0 + 76); rst = 1'b0;
    t1 = edge_n + 1;
    goto(t1 + 25); rst = 1'b1;
    goto(t1 + 26);
    chk("lit.A.rst_cmd", 32'(ifa.init_cmd), 32'h7);
    chk("lit.A.rst_addr", 32'(ifa.init_addr), 32'h1FFF);
    chk("lit.A.rst_busy", 32'(ifa.init_busy), 32'h1);
    rst = 1'b0;
    t2 = edge_n + 1;
    goto(t2 + 19); chk("lit.A.rst_nop19", 32'(ifa.init_cmd), 32'h7);
    goto(t2 + 20); chk("lit.A.rst_pre20", 32'(ifa.init_cmd), 32'h2);
    goto(t2 + 45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
